// File: rtl/dotmatrix_pkg.sv
// Shared definitions for the dot-matrix scroll sequencer.
//   state_t           : sequencer FSM state encoding
//   STRB_BYTE0        : byte strobe used for every row write
//   NUM_ROWS          : rows in the pattern buffer / writes per frame
//   DEFAULT_BASE_ADDR : default slave register address of row 0
package dotmatrix_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [3:0] STRB_BYTE0        = 4'b0001;
    localparam int         NUM_ROWS          = 8;
    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h00;

endpackage

// File: rtl/dm_rotate8.sv
// Combinational 8-bit rotate.
//   i_data : byte to rotate
//   i_amt  : rotate amount 0..7 (0 passes data unchanged)
//   i_dir  : 0 = rotate left, 1 = rotate right
//   o_data : rotated byte
module dm_rotate8 (
    input  logic [7:0] i_data,
    input  logic [2:0] i_amt,
    input  logic       i_dir,
    output logic [7:0] o_data
);

    logic [15:0] w_dbl;
    logic [15:0] w_shl;
    logic [15:0] w_shr;

    // Doubling the byte turns a rotate into a plain shift of the pair:
    // the upper byte of a left shift or the lower byte of a right shift.
    assign w_dbl  = {i_data, i_data};
    assign w_shl  = w_dbl << i_amt;
    assign w_shr  = w_dbl >> i_amt;
    assign o_data = i_dir ? w_shr[7:0] : w_shl[15:8];

endmodule

// File: rtl/dotmatrix_scroll_seq.sv
// Bus-master sequencer pushing an 8-row pattern frame to the dot-matrix
// slave as CS/Write transactions, with optional periodic scrolling.
//   mclock, mreset        : clock, synchronous active-high reset
//   ld_we/ld_addr/ld_data : host write port into the pattern buffer
//   start                 : one-cycle pulse requesting a frame now
//   scroll_en, scroll_dir : periodic frames + offset advance, rotate direction
//   CS/Write/Read/Address/Data_o/STRB, ack : slave register bus
//   busy, frame_done, err : frame status (done/err are one-cycle pulses)
//   offset                : current scroll offset
module dotmatrix_scroll_seq
    import dotmatrix_pkg::*;
#(
    parameter logic [23:0] SCROLL_DIV  = 24'd12_000_000,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd64,
    parameter logic [7:0]  BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic       mclock,
    input  logic       mreset,
    input  logic       ld_we,
    input  logic [2:0] ld_addr,
    input  logic [7:0] ld_data,
    input  logic       start,
    input  logic       scroll_en,
    input  logic       scroll_dir,
    output logic       CS,
    output logic       Write,
    output logic       Read,
    output logic [7:0] Address,
    output logic [7:0] Data_o,
    output logic [3:0] STRB,
    input  logic       ack,
    output logic       busy,
    output logic       frame_done,
    output logic       err,
    output logic [2:0] offset
);

    localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

    logic [7:0]  r_buf [NUM_ROWS];
    logic [23:0] r_tick_cnt;
    logic        r_pending;
    logic        r_tk;
    logic        r_frame_tk;
    logic [2:0]  r_row;
    logic [7:0]  r_to_cnt;
    state_t      r_state;
    logic        r_cs;
    logic        r_write;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic [3:0]  r_strb;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_err;
    logic [2:0]  r_offset;

    logic        w_tick;
    logic        w_req;
    logic [7:0]  w_rot;

    // Tick counter: free-runs only while scrolling is enabled.
    always_ff @(posedge mclock) begin
        if (mreset || !scroll_en) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 24'd1;
        end
    end

    assign w_tick = scroll_en && (r_tick_cnt == SCROLL_DIV - 24'd1);
    assign w_req  = start || w_tick;

    // Rotation uses the live direction and the current offset.
    dm_rotate8 u_rot (
        .i_data (r_buf[r_row]),
        .i_amt  (r_offset),
        .i_dir  (scroll_dir),
        .o_data (w_rot)
    );

    always_ff @(posedge mclock) begin
        if (mreset) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_buf[i] <= 8'h00;
            end
            r_pending    <= 1'b0;
            r_tk         <= 1'b0;
            r_frame_tk   <= 1'b0;
            r_row        <= 3'd0;
            r_to_cnt     <= 8'd0;
            r_state      <= S_IDLE;
            r_cs         <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= 8'h00;
            r_data       <= 8'h00;
            r_strb       <= 4'h0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_offset     <= 3'd0;
        end else begin
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;

            // Row reads in ISSUE see the pre-edge contents, so a write
            // landing on the row being issued only affects later frames.
            if (ld_we) begin
                r_buf[ld_addr] <= ld_data;
            end

            // Single-slot request latch; requests during a frame merge.
            if (w_req) begin
                r_pending <= 1'b1;
                r_tk      <= r_tk | w_tick;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        // A request arriving on the consume cycle refills the slot.
                        r_pending  <= w_req;
                        r_tk       <= w_tick;
                        r_frame_tk <= r_tk;
                        r_row      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cs     <= 1'b1;
                    r_write  <= 1'b1;
                    r_strb   <= STRB_BYTE0;
                    r_addr   <= BASE_ADDR + {5'b00000, r_row};
                    r_data   <= w_rot;
                    r_to_cnt <= 8'd0;
                    r_state  <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack) begin
                        r_cs    <= 1'b0;
                        r_write <= 1'b0;
                        r_strb  <= 4'h0;
                        r_addr  <= 8'h00;
                        r_data  <= 8'h00;
                        r_state <= S_GAP;
                    end else if (r_to_cnt == ACK_TIMEOUT - 8'd1) begin
                        // Abandon the frame; offset stays where it was.
                        r_cs    <= 1'b0;
                        r_write <= 1'b0;
                        r_strb  <= 4'h0;
                        r_addr  <= 8'h00;
                        r_data  <= 8'h00;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_row == LAST_ROW) begin
                        r_state <= S_DONE;
                    end else begin
                        r_row   <= r_row + 3'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    if (r_frame_tk) begin
                        r_offset <= r_offset + 3'd1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CS         = r_cs;
    assign Write      = r_write;
    assign Read       = 1'b0;
    assign Address    = r_addr;
    assign Data_o     = r_data;
    assign STRB       = r_strb;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign offset     = r_offset;

endmodule

// File: doc/dotmatrix_scroll_seq.md
Name: dotmatrix_scroll_seq

Overview:
Bus-master sequencer for the dot-matrix display register interface. Holds an 8-row pattern buffer loaded by a host. On a start pulse, or periodically when scrolling is enabled, it pushes the whole frame to the dotmatrix slave as 8 CS/Write transactions with ack handshake. Each row byte is rotated by a scroll offset that advances after every periodic frame. It replaces the hard-coded write state machine in the top level.

Parameters:
SCROLL_DIV, 24'd12_000_000, mclock cycles between periodic frames (must be >= 32)
ACK_TIMEOUT, 8'd64, cycles to wait for ack before aborting the frame
BASE_ADDR, 8'h00, slave register address of row 0

Ports:
mclock  in  1  system clock
mreset  in  1  synchronous, active-high reset
ld_we  in  1  pattern buffer write strobe
ld_addr  in  3  pattern row index
ld_data  in  8  pattern row data
start  in  1  one-cycle pulse: push frame now
scroll_en  in  1  enables periodic frames and offset advance
scroll_dir  in  1  0 = rotate left, 1 = rotate right
CS  out  1  slave chip select
Write  out  1  slave write strobe
Read  out  1  slave read strobe (tied 0)
Address  out  8  slave register address
Data_o  out  8  write data to slave Data_i
STRB  out  4  byte strobe
ack  in  1  slave acknowledge
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse, frame completed
err  out  1  one-cycle pulse, ack timeout
offset  out  3  current scroll offset

Behaviour:
- Interface: one clock, mclock. Reset mreset is synchronous and active-high.
- Reset state:
  - CS, Write, Read, busy, frame_done, err = 0.
  - Address, Data_o = 8'h00; STRB = 4'h0; offset = 0.
  - Pattern buffer cleared to 8'h00; tick counter = 0; pending = 0; FSM = IDLE.
- Reset mid-frame aborts the frame immediately with no further bus activity.
- Pattern buffer:
  - ld_we writes buf[ld_addr] at the clock edge; the buffer is writable at any time, including mid-frame.
  - Each row is read when that row is issued. Same-cycle write and issue of the same row: the old value is sent.
- Tick counter:
  - Free-runs 0..SCROLL_DIV-1 while scroll_en = 1; held at 0 while scroll_en = 0.
  - Generates a tick when it wraps.
- Request latch:
  - start or tick sets pending. Its tick flag (tk) ORs in tick.
  - start and tick in the same cycle = one request with tk = 1.
  - Requests arriving while busy merge into the single pending slot; no queueing beyond depth 1.
- FSM states: IDLE, ISSUE, WAIT_ACK, GAP, DONE.
- IDLE:
  - If pending, clear pending, capture tk into frame_tk, set row = 0, busy = 1, go to ISSUE.
- ISSUE (1 cycle):
  - Drive CS = 1, Write = 1, STRB = 4'b0001.
  - Address = BASE_ADDR + row (8-bit wrap).
  - Data_o = buf[row] rotated by offset (left if scroll_dir = 0, right if 1); offset 0 passes data unchanged.
  - Load timeout counter = 0; go to WAIT_ACK.
- WAIT_ACK:
  - Hold all bus outputs stable.
  - If ack = 1: drop CS, Write, STRB next cycle, Data_o and Address to 0, go to GAP.
  - Else if timeout counter = ACK_TIMEOUT-1: pulse err, drop bus outputs, busy = 0, go to IDLE. The frame is abandoned and offset is not advanced.
- GAP (1 cycle, bus idle):
  - If row = 7, go to DONE; else row + 1, go to ISSUE.
- DONE:
  - Pulse frame_done; busy = 0.
  - If frame_tk, offset = offset + 1 (mod 8, wraps 7 -> 0) regardless of direction; direction only affects the rotate.
  - Go to IDLE.
- Timing:
  - Minimum frame with ack returned the cycle after ISSUE = 1 + 8 x 3 + 1 = 26 cycles from pending set to frame_done.
  - scroll_dir and scroll_en are sampled live; scroll_dir change mid-frame affects the remaining rows.
- Read is constant 0; Data_i from the slave is unused.

Decomposition:
- Shared package dotmatrix_pkg:
  - FSM state encoding.
  - Constants STRB_BYTE0 = 4'b0001 and NUM_ROWS = 8.
  - Default BASE_ADDR.
- One natural sub-module, dm_rotate8: combinational 8-bit rotate by a 3-bit amount with direction. Everything else stays flat.

Test Plan:
- Load buf = 01,02,04,08,10,20,40,80; start with ack returned 1 cycle after CS -> 8 writes, Address 00..07, Data_o equal to buf; frame_done at cycle 26; offset stays 0.
- scroll_en = 1, SCROLL_DIV = 32, scroll_dir = 0, buf[0] = 8'h81 -> successive frames send row 0 as 81, 03, 06, 0C; offset reaches 0 after 8 frames (wrap).
- scroll_dir = 1, offset = 1, buf[3] = 8'h01 -> row 3 written as 8'h80 at Address 03.
- Slave never acks -> CS held for exactly ACK_TIMEOUT cycles; err pulses once; busy falls; no further writes; offset unchanged.
- start issued during a frame, twice -> exactly one additional frame after frame_done.
- Assert mreset during WAIT_ACK of row 4 -> next cycle CS = 0, busy = 0, offset = 0, buffer reads 00; a following start sends eight 00 writes.
